ntt_bf_sequencer: RTL and testbench

//  Schedules the butterfly unit of the iterative in-place NTT core: walks stages,

---
 rtl/ntt_bf_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_ntt_bf_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bf_sequencer.sv
// Butterfly scheduler for an iterative in-place radix-2 NTT: issues (addr_a, addr_b, tw_idx)
// per butterfly with an idle gap between stages. Define NTT_SEQ_INVERSE_EN to add 'inverse'.
module ntt_bf_sequencer #(
  parameter int LOG_N     = 3,
  parameter int STAGE_GAP = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
`ifdef NTT_SEQ_INVERSE_EN
  input  logic                                          inverse,
`endif
  input  logic                                          bf_ready,
  output logic                                          bf_valid,
  output logic [LOG_N-1:0]                              addr_a,
  output logic [LOG_N-1:0]                              addr_b,
  output logic [LOG_N-2:0]                              tw_idx,
  output logic [((LOG_N > 1) ? $clog2(LOG_N) : 1)-1:0]  stage,
  output logic                                          busy,
  output logic                                          done
);

  localparam int SW       = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam int CW       = LOG_N - 1;
  localparam int GW       = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int GAP_LAST = (STAGE_GAP > 0) ? STAGE_GAP - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  typedef struct packed {
    logic [LOG_N-1:0] a;
    logic [LOG_N-1:0] b;
    logic [CW-1:0]    tw;
  } triple_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [CW-1:0]   c_q, c_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            bf_valid_q, bf_valid_d;
  triple_t         trip_q, trip_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [SW-1:0]   first_s, last_s, next_s;

  // Butterfly c of stage s: groups of 2*half points, twiddle stride shrinks as s grows.
  function automatic triple_t calc(input logic [SW-1:0] s, input logic [CW-1:0] c);
    logic [LOG_N-1:0] cx, half, k, g, a;
    logic [SW-1:0]    sh;
    triple_t          r;
    cx   = {1'b0, c};
    half = LOG_N'(1) << s;
    k    = cx & (half - LOG_N'(1));
    g    = cx >> s;
    a    = ((g << s) << 1) | k;
    sh   = SW'(LOG_N - 1) - s;
    r.a  = a;
    r.b  = a + half;
    r.tw = CW'(k << sh);
    return r;
  endfunction

`ifdef NTT_SEQ_INVERSE_EN
  logic inv_q, inv_d;
  assign first_s = inverse ? SW'(LOG_N - 1) : '0;
  assign last_s  = inv_q ? '0 : SW'(LOG_N - 1);
  assign next_s  = inv_q ? s_q - SW'(1) : s_q + SW'(1);
`else
  assign first_s = '0;
  assign last_s  = SW'(LOG_N - 1);
  assign next_s  = s_q + SW'(1);
`endif

  always_comb begin
    // NOTE: every *_d gets a hold/default value first, so no path can infer a latch.
    state_d    = state_q;
    s_d        = s_q;
    c_d        = c_q;
    gap_d      = gap_q;
    bf_valid_d = bf_valid_q;
    trip_d     = trip_q;
    stage_d    = stage_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef NTT_SEQ_INVERSE_EN
    inv_d      = inv_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          s_d        = first_s;
          c_d        = '0;
          bf_valid_d = 1'b1;
          busy_d     = 1'b1;
          trip_d     = calc(first_s, '0);
          stage_d    = first_s;
`ifdef NTT_SEQ_INVERSE_EN
          inv_d      = inverse;
`endif
        end
      end
      S_RUN: begin
        if (bf_valid_q && bf_ready) begin
          if (c_q == '1) begin
            c_d = '0;
            if (s_q == last_s) begin
              state_d    = S_DONE;
              bf_valid_d = 1'b0;
              busy_d     = 1'b0;
              done_d     = 1'b1;
            end else begin
              s_d = next_s;
              if (STAGE_GAP > 0) begin
                state_d    = S_GAP;
                gap_d      = '0;
                bf_valid_d = 1'b0;
              end else begin
                trip_d  = calc(next_s, '0);
                stage_d = next_s;
              end
            end
          end else begin
            c_d    = c_q + CW'(1);
            trip_d = calc(s_q, c_q + CW'(1));
          end
        end
      end
      S_GAP: begin
        // Triple outputs keep the last issued values until the new stage starts.
        if (gap_q == GW'(GAP_LAST)) begin
          state_d    = S_RUN;
          bf_valid_d = 1'b1;
          trip_d     = calc(s_q, '0);
          stage_d    = s_q;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      s_q        <= '0;
      c_q        <= '0;
      gap_q      <= '0;
      bf_valid_q <= 1'b0;
      trip_q     <= '0;
      stage_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef NTT_SEQ_INVERSE_EN
      inv_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      c_q        <= c_d;
      gap_q      <= gap_d;
      bf_valid_q <= bf_valid_d;
      trip_q     <= trip_d;
      stage_q    <= stage_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef NTT_SEQ_INVERSE_EN
      inv_q      <= inv_d;
`endif
    end
  end

  assign bf_valid = bf_valid_q;
  assign addr_a   = trip_q.a;
  assign addr_b   = trip_q.b;
  assign tw_idx   = trip_q.tw;
  assign stage    = stage_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ntt_bf_sequencer.sv
// Scoreboard bench for ntt_bf_sequencer: dut0 uses STAGE_GAP=2, dut1 uses STAGE_GAP=0.
// Cycle n runs from rising edge n to n+1; start is driven during cycle 0 of each run.
module tb_ntt_bf_sequencer;

  localparam int LOG_N = 3;
  localparam int SW    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start0, start1, bf_ready;
`ifdef NTT_SEQ_INVERSE_EN
  logic inverse;
`endif

  logic             v0, v1, busy0, busy1, done0, done1;
  logic [LOG_N-1:0] a0, b0, a1, b1;
  logic [LOG_N-2:0] tw0, tw1;
  logic [SW-1:0]    st0, st1;

  ntt_bf_sequencer #(.LOG_N(LOG_N), .STAGE_GAP(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
`ifdef NTT_SEQ_INVERSE_EN
    .inverse(inverse),
`endif
    .bf_ready(bf_ready), .bf_valid(v0), .addr_a(a0), .addr_b(b0), .tw_idx(tw0),
    .stage(st0), .busy(busy0), .done(done0));

  ntt_bf_sequencer #(.LOG_N(LOG_N), .STAGE_GAP(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
`ifdef NTT_SEQ_INVERSE_EN
    .inverse(inverse),
`endif
    .bf_ready(bf_ready), .bf_valid(v1), .addr_a(a1), .addr_b(b1), .tw_idx(tw1),
    .stage(st1), .busy(busy1), .done(done1));

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-derived triples, index = stage*4 + butterfly.
  int tbl_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int tbl_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int tbl_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  logic [9:0] sb0[$];
  logic [9:0] sb1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] pk(input logic [2:0] a, input logic [2:0] b,
                                    input logic [1:0] tw, input logic [1:0] st);
    return {a, b, tw, st};
  endfunction

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic push_seq(input int sel, input int first_stage, input int dir, input int count);
    int st, idx;
    logic [9:0] e;
    for (int k = 0; k < count; k++) begin
      st  = first_stage + dir * (k / 4);
      idx = st * 4 + (k % 4);
      e   = pk(3'(tbl_a[idx]), 3'(tbl_b[idx]), 2'(tbl_tw[idx]), 2'(st));
      if (sel == 0) sb0.push_back(e);
      else          sb1.push_back(e);
    end
  endtask

  // Monitors: pop and compare on every transfer, and check stability across stalls.
  initial begin : mon0
    logic [9:0] held, cur, e;
    bit hv;
    hv = 0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = pk(a0, b0, tw0, st0);
      if (rst !== 1'b1) hv = 0;
      else begin
        if (hv) check("stall0 hold", {v0, cur}, {1'b1, held});
        if (v0 && bf_ready) begin
          if (sb0.size() == 0) check("xfer0 unexpected", 64'(sb0.size()), 1);
          else begin
            e = sb0.pop_front();
            check("xfer0 triple", cur, e);
          end
        end
        hv   = v0 && !bf_ready;
        held = cur;
      end
    end
  end

  initial begin : mon1
    logic [9:0] cur, e;
    forever begin
      @(negedge clk);
      cur = pk(a1, b1, tw1, st1);
      if (rst === 1'b1 && v1 && bf_ready) begin
        if (sb1.size() == 0) check("xfer1 unexpected", 64'(sb1.size()), 1);
        else begin
          e = sb1.pop_front();
          check("xfer1 triple", cur, e);
        end
      end
    end
  end

  // Runs cycles 0..ncyc, logging valid/done/busy/transfer/any-output per cycle.
  task automatic run(input int sel, input int ncyc, input logic [63:0] start_m,
                     input logic [63:0] rstlo_m, input bit stall,
                     output logic [63:0] vlog, output logic [63:0] dlog,
                     output logic [63:0] blog, output logic [63:0] xlog,
                     output logic [63:0] olog);
    logic v, d, b;
    logic [9:0] o;
    vlog = '0; dlog = '0; blog = '0; xlog = '0; olog = '0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc <= ncyc; cyc++) begin
      if (sel == 0) start0 = start_m[cyc];
      else          start1 = start_m[cyc];
      rst      = !rstlo_m[cyc];
      bf_ready = stall ? ((cyc % 3) == 1) : 1'b1;
      @(negedge clk);
      v = (sel == 0) ? v0 : v1;
      d = (sel == 0) ? done0 : done1;
      b = (sel == 0) ? busy0 : busy1;
      o = (sel == 0) ? pk(a0, b0, tw0, st0) : pk(a1, b1, tw1, st1);
      vlog[cyc] = v;
      dlog[cyc] = d;
      blog[cyc] = b;
      xlog[cyc] = v & bf_ready & rst;
      olog[cyc] = v | d | b | (|o);
      @(posedge clk); #1;
    end
    start0 = 1'b0; start1 = 1'b0; rst = 1'b1; bf_ready = 1'b1;
  endtask

  logic [63:0] vl, dl, bl, xl, ol;

  initial begin
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; bf_ready = 1'b1;
`ifdef NTT_SEQ_INVERSE_EN
    inverse = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset bf_valid", v0, 0);
    check("reset addr_a", a0, 0);
    check("reset addr_b", b0, 0);
    check("reset tw_idx", tw0, 0);
    check("reset stage", st0, 0);
    check("reset busy", busy0, 0);
    check("reset done", done0, 0);
    check("reset dut1 outputs", {v1, a1, b1, tw1, st1, busy1, done1}, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Forward transform, always ready.
    push_seq(0, 0, 1, 12);
    run(0, 18, 64'h1, 64'h0, 1'b0, vl, dl, bl, xl, ol);
    check("t1 valid cycles", vl, rng(1, 4) | rng(7, 10) | rng(13, 16));
    check("t1 done cycle", dl, rng(17, 17));
    check("t1 busy cycles", bl, rng(1, 16));
    check("t1 sb drained", 64'(sb0.size()), 0);

    // Ready pattern 1,0,0 repeating from cycle 1.
    push_seq(0, 0, 1, 12);
    run(0, 40, 64'h1, 64'h0, 1'b1, vl, dl, bl, xl, ol);
    check("t2 transfer cycles", xl, 64'h0000_0004_9249_2492);
    check("t2 done cycle", dl, rng(35, 35));
    check("t2 sb drained", 64'(sb0.size()), 0);

    // Zero stage gap: back-to-back stages.
    push_seq(1, 0, 1, 12);
    run(1, 14, 64'h1, 64'h0, 1'b0, vl, dl, bl, xl, ol);
    check("t3 valid cycles", vl, rng(1, 12));
    check("t3 done cycle", dl, rng(13, 13));
    check("t3 sb drained", 64'(sb1.size()), 0);

    // Start pulses mid-run are ignored; reset in cycle 9 aborts.
    push_seq(0, 0, 1, 6);
    run(0, 14, rng(0, 0) | rng(3, 3) | rng(8, 8), rng(9, 9), 1'b0, vl, dl, bl, xl, ol);
    check("t4 transfer cycles", xl, rng(1, 4) | rng(7, 8));
    check("t4 no done", dl, 0);
    check("t4 outputs zero after reset", ol & rng(10, 14), 0);
    check("t4 sb drained", 64'(sb0.size()), 0);

`ifdef NTT_SEQ_INVERSE_EN
    // Inverse order: stage 2 first, stage 0 last.
    inverse = 1'b1;
    push_seq(0, 2, -1, 12);
    run(0, 18, 64'h1, 64'h0, 1'b0, vl, dl, bl, xl, ol);
    inverse = 1'b0;
    check("t5 valid cycles", vl, rng(1, 4) | rng(7, 10) | rng(13, 16));
    check("t5 done cycle", dl, rng(17, 17));
    check("t5 sb drained", 64'(sb0.size()), 0);
`endif

    // Start held high: second transform begins right after returning to idle.
    push_seq(0, 0, 1, 12);
    push_seq(0, 0, 1, 12);
    run(0, 37, rng(0, 20), 64'h0, 1'b0, vl, dl, bl, xl, ol);
    check("t6 valid cycles", vl, rng(1, 4) | rng(7, 10) | rng(13, 16) |
                                 rng(19, 22) | rng(25, 28) | rng(31, 34));
    check("t6 done cycles", dl, rng(17, 17) | rng(35, 35));
    check("t6 sb drained", 64'(sb0.size()), 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
